hex_page_scheduler: RTL
=======================

Name: hex_page_scheduler

Overview:
- Shares the board's 7-segment display between up to NUM_REQ demo sub-blocks. Examples of sub-blocks: counters, the roman encoder and the bound flasher status.
- Each requester raises req and presents a DATA_W-bit value. The scheduler grants one requester at a time.
- In AUTO mode it rotates round-robin on a programmable dwell. In MANUAL mode it advances on a single-cycle next_pulse, typically driven by a KEY through the edge detector.
- The registered winning value feeds the bin27seg decoders in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of grant index; must equal clog2(NUM_REQ).
- DATA_W, 16, display value width (4 hex digits).
- TICK_MAX, 25'd24999999, tick divider terminal count (0.5 s at 50 MHz).
- HOLD_TICKS, 4, ticks a grant is held in AUTO mode (>=1).

Ports:
- clk  input  1  system clock (CLOCK_50).
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request per requester; level-sensitive.
- data  input  NUM_REQ*DATA_W  packed values; requester i occupies [i*DATA_W +: DATA_W].
- mode_sel  input  1  0 = AUTO rotate, 1 = MANUAL.
- next_pulse  input  1  single-cycle advance request.
- grant  output  NUM_REQ  one-hot grant; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the granted requester.
- disp_data  output  DATA_W  registered value of the granted requester.
- disp_valid  output  1  disp_data is meaningful.
- tick  output  1  one-cycle pulse at divider terminal count.

Behaviour:
- Reset values: grant=0, grant_idx=0, disp_data=0, disp_valid=0, tick=0, divider=0, hold counter=0. State is IDLE.
- Divider counts 0..TICK_MAX and wraps to 0. tick=1 in the cycle the count equals TICK_MAX. The divider free-runs in every state.
- States:
  - IDLE: grant=0, disp_valid=0, disp_data=0. Any req bit high moves to SHOW next cycle. The granted requester is the lowest index >= last_idx+1 (mod NUM_REQ) with req high. last_idx resets to NUM_REQ-1, so the first grant searches from 0.
  - SHOW: grant/grant_idx are stable. disp_data <= data[grant_idx] every cycle, giving 1-cycle latency from data to disp_data. disp_valid=1.
- Advance (SHOW): next granted index = first requester with req high, searching circularly from grant_idx+1. If the current requester is the only active one, the grant is kept and the hold counter is cleared.
- AUTO mode: hold counter increments on tick. When it reaches HOLD_TICKS-1 and tick=1, the scheduler advances and the counter clears. next_pulse is ignored.
- MANUAL mode: the hold counter is held at 0. Each next_pulse advances once.
- Granted requester drops req:
  - Next cycle, re-arbitrate as an advance.
  - If no req remains, go to IDLE and clear outputs. last_idx keeps the dropped index.
- Simultaneous hold expiry and next_pulse: exactly one advance.
- A mode_sel change clears the hold counter and keeps the current grant.
- Reset asserted mid-SHOW forces all reset values immediately (asynchronous).
- Changes to req bits other than the granted one never preempt the current grant.

Optional Feature:
- Macro: HEX_SCHED_BLANK_EN.
- When defined, every grant change passes through a BLANK state of exactly one tick period. Entry to BLANK is the advance cycle; exit is the next tick.
  - During BLANK: disp_valid=0, disp_data=0, grant=0.
  - On exit: grant goes to the index chosen at entry, if that requester's req is still high. Otherwise re-arbitrate from that index; if nothing is pending, go to IDLE.
- When not defined, grant changes take effect in the cycle after the advance condition with no blank gap.

Test Plan:
- Bench settings: TICK_MAX=3 and HOLD_TICKS=2 in all cases.
1. Reset held, req=4'b1111 -> grant=0, disp_valid=0, disp_data=0. After release, the next cycle gives grant=4'b0001, grant_idx=0, and the following cycle gives disp_data=data[0].
2. AUTO, req=4'b1111, data[i]=16'h1111*(i+1) -> grant changes every 8 cycles in the order 0,1,2,3,0. disp_data goes 1111,2222,3333,4444,1111 with 1-cycle lag.
3. AUTO, req=4'b0101 -> grant alternates 0,2,0. Setting req=4'b0001 while granted 0 -> grant stays 0 and the hold counter restarts.
4. MANUAL, req=4'b1011, next_pulse pulsed 3 times spaced 5 cycles -> grant_idx goes 0->1->3->0. Ticks never advance the grant.
5. Granted idx 1 in SHOW, req drops to 0 -> next cycle: IDLE, grant=0, disp_valid=0. Then req=4'b0011 -> grant_idx=0 (search from 2 wraps to 0).
6. MANUAL, next_pulse coincident with mode_sel->AUTO on the expiry cycle -> exactly one advance. With HEX_SCHED_BLANK_EN, disp_valid is low for exactly one tick period at each change.

Source files
------------

// File: rtl/hex_page_scheduler.sv
// hex_page_scheduler: shares the 7-segment display among NUM_REQ requesters, rotating on a tick-based dwell (AUTO) or on next_pulse (MANUAL).
// Define HEX_SCHED_BLANK_EN to insert a one-tick blank gap on every grant change.
module hex_page_scheduler #(
    parameter int          NUM_REQ    = 4,
    parameter int          IDX_W      = 2,
    parameter int          DATA_W     = 16,
    parameter logic [24:0] TICK_MAX   = 25'd24999999,
    parameter int          HOLD_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    input  logic                      mode_sel,
    input  logic                      next_pulse,
    output logic [NUM_REQ-1:0]        grant,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [DATA_W-1:0]         disp_data,
    output logic                      disp_valid,
    output logic                      tick
);
    localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    state_t           state, state_n;
    logic [24:0]      div;
    logic [HW-1:0]    hold, hold_n;
    logic [IDX_W-1:0] last_idx, idx_n, base, nidx;
    logic             found, mode_q, drop, expiry, adv;
    // Circular search starting just after b; b itself is considered last.
    function automatic logic [IDX_W:0] find(input logic [NUM_REQ-1:0] r, input logic [IDX_W-1:0] b);
        int j;
        find = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(b) + k) % NUM_REQ;
            if (r[j]) find = {1'b1, IDX_W'(j)};
        end
    endfunction
    assign tick = div == TICK_MAX;
    assign base = state == IDLE ? last_idx : grant_idx;
    assign {found, nidx} = find(req, base);
    assign drop = state == SHOW && !req[grant_idx];
    // A mode change in either direction blocks expiry; next_pulse counts if either side of the change is MANUAL.
    assign expiry = !mode_sel && !mode_q && tick && hold == HW'(HOLD_TICKS - 1);
    assign adv = drop || expiry || (next_pulse && (mode_sel || mode_q));
    assign grant = state == SHOW ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx : '0;
    always_comb begin
        state_n = state;
        idx_n = grant_idx;
        hold_n = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = SHOW;
                    idx_n = nidx;
                end
            end
            SHOW: begin
                hold_n = (adv || mode_sel || mode_q) ? '0 : hold + HW'(tick);
                if (adv) begin
                    idx_n = found ? nidx : grant_idx;
`ifdef HEX_SCHED_BLANK_EN
                    state_n = !found ? IDLE : (nidx != grant_idx ? BLANK : SHOW);
`else
                    state_n = found ? SHOW : IDLE;
`endif
                end
            end
`ifdef HEX_SCHED_BLANK_EN
            BLANK: begin
                if (tick) begin
                    state_n = (req[grant_idx] || found) ? SHOW : IDLE;
                    idx_n = (req[grant_idx] || !found) ? grant_idx : nidx;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div <= '0;
            hold <= '0;
            grant_idx <= '0;
            last_idx <= IDX_W'(NUM_REQ - 1);
            disp_data <= '0;
            disp_valid <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state <= state_n;
            div <= tick ? '0 : div + 25'd1;
            hold <= hold_n;
            grant_idx <= idx_n;
            last_idx <= state == IDLE ? last_idx : grant_idx;
            disp_valid <= state == SHOW && state_n == SHOW;
            disp_data <= (state == SHOW && state_n == SHOW) ? data[grant_idx*DATA_W +: DATA_W] : '0;
            mode_q <= mode_sel;
        end
    end
endmodule
